// File: rtl/hash_compare_multi_if.sv
`default_nettype none
// ============================================================================
// hash_compare_multi_if : lane-result inputs and found-nonce output port
// Revision: 1.0
// ============================================================================
interface hash_compare_multi_if #(
  parameter int LANES = 4
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [63:0]         target;
  logic [LANES-1:0]    in_valid;
  logic [64*LANES-1:0] m04;
  logic [64*LANES-1:0] v0;
  logic [64*LANES-1:0] v8;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_nonce;
  logic [LANE_W-1:0]   out_lane;

  modport master (
    output target, in_valid, m04, v0, v8, out_ready,
    input  out_valid, out_nonce, out_lane
  );

  modport slave (
    input  target, in_valid, m04, v0, v8, out_ready,
    output out_valid, out_nonce, out_lane
  );
endinterface
`default_nettype wire

// File: rtl/hash_compare_multi.sv
`default_nettype none
// ============================================================================
// hash_compare_multi : multi-lane Blake2b target comparator with found-nonce FIFO
// Revision: 1.0
// ============================================================================
module hash_compare_multi #(
  parameter int          LANES      = 4,
  parameter int          CMP_BITS   = 40,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 48,
  parameter logic [63:0] IV0        = 64'h6a09e667f2bdc928
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  hash_compare_multi_if.slave bus,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] hash_cnt
);

  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FCNT_W  = PTR_W + 1;
  localparam int ENTRY_W = LANE_W + 32;
  localparam int SUM_W   = CNT_W + 5;

  logic [LANES-1:0]           hit_w;
  logic [LANES-1:0][31:0]     nonce_w;

  logic [LANES-1:0]           pend_q, pend_d;
  logic [LANES-1:0][31:0]     slot_q, slot_d;
  logic                       overflow_q, overflow_d;
  logic                       vld_any_q;
  logic [LANE_W-1:0]          rr_ptr_q;
  logic [CNT_W-1:0]           hash_cnt_q;

  logic [FIFO_DEPTH-1:0][ENTRY_W-1:0] mem_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]          count_q;

  logic                       out_valid_w, full_w, pop_w, push_w, push_ok_w;
  logic                       gnt_vld_w;
  logic [LANE_W-1:0]          gnt_idx_w;
  logic [4:0]                 pop_cnt_w;
  logic [SUM_W-1:0]           sum_w;
  logic                       unused_w;

  assign unused_w = ^bus.target;

  // Per-lane fold, byte swap, strict unsigned compare and nonce swap
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [63:0] h0_w;
      logic [63:0] swap8_w;
      logic [31:0] m_w;
      logic        lane_unused_w;

      assign h0_w = IV0 ^ bus.v0[64*gi +: 64] ^ bus.v8[64*gi +: 64];
      for (genvar b = 0; b < 8; b++) begin : g_swap
        assign swap8_w[8*b +: 8] = h0_w[8*(7-b) +: 8];
      end
      assign m_w           = bus.m04[64*gi +: 32];
      assign nonce_w[gi]   = {m_w[7:0], m_w[15:8], m_w[23:16], m_w[31:24]};
      assign hit_w[gi]     = bus.in_valid[gi] &
                             (swap8_w[CMP_BITS-1:0] < bus.target[CMP_BITS-1:0]);
      assign lane_unused_w = ^{swap8_w, bus.m04[64*gi+32 +: 32]};
    end
  endgenerate

  assign out_valid_w = (count_q != '0);
  assign full_w      = (count_q == FCNT_W'(FIFO_DEPTH));
  assign pop_w       = out_valid_w & bus.out_ready & ~clear;
  assign push_ok_w   = ~full_w | pop_w;
  assign push_w      = gnt_vld_w & ~clear;

  // Round-robin search over registered pending flags, starting at rr_ptr
  always_comb begin
    int idx;
    idx       = 0;
    gnt_vld_w = 1'b0;
    gnt_idx_w = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= LANES) idx = idx - LANES;
      if (!gnt_vld_w && pend_q[idx]) begin
        gnt_vld_w = 1'b1;
        gnt_idx_w = LANE_W'(idx);
      end
    end
    if (!push_ok_w) gnt_vld_w = 1'b0;
  end

  // A slot freed by this cycle's grant can take a new hit in the same cycle
  always_comb begin
    pend_d     = pend_q;
    slot_d     = slot_q;
    overflow_d = overflow_q;
    for (int i = 0; i < LANES; i++) begin
      if (push_w && (gnt_idx_w == LANE_W'(i))) pend_d[i] = 1'b0;
      if (hit_w[i]) begin
        if (!pend_q[i] || (push_w && (gnt_idx_w == LANE_W'(i)))) begin
          pend_d[i] = 1'b1;
          slot_d[i] = nonce_w[i];
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
    if (clear) begin
      pend_d     = '0;
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    pop_cnt_w = '0;
    for (int i = 0; i < LANES; i++) pop_cnt_w = pop_cnt_w + 5'(bus.in_valid[i]);
  end

  assign sum_w = {5'd0, hash_cnt_q} + SUM_W'(pop_cnt_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      slot_q     <= '0;
      overflow_q <= 1'b0;
      vld_any_q  <= 1'b0;
      rr_ptr_q   <= '0;
      hash_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      slot_q     <= slot_d;
      overflow_q <= overflow_d;
      vld_any_q  <= ~clear & (|bus.in_valid);
      if (clear) begin
        rr_ptr_q   <= '0;
        hash_cnt_q <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (push_w) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          rr_ptr_q <= (gnt_idx_w == LANE_W'(LANES - 1)) ? '0 : gnt_idx_w + LANE_W'(1);
        end
        if (pop_w) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        case ({push_w, pop_w})
          2'b10:   count_q <= count_q + FCNT_W'(1);
          2'b01:   count_q <= count_q - FCNT_W'(1);
          default: count_q <= count_q;
        endcase
        if (sum_w[SUM_W-1:CNT_W] != '0) hash_cnt_q <= '1;
        else                            hash_cnt_q <= sum_w[CNT_W-1:0];
      end
    end
  end

  // Storage needs no reset: head is only visible while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q] <= {gnt_idx_w, slot_q[gnt_idx_w]};
  end

  assign bus.out_valid = out_valid_w;
  assign bus.out_nonce = out_valid_w ? mem_q[rd_ptr_q][31:0] : 32'd0;
  assign bus.out_lane  = out_valid_w ? mem_q[rd_ptr_q][ENTRY_W-1:32] : '0;
  assign busy          = vld_any_q | (|pend_q) | out_valid_w;
  assign overflow      = overflow_q;
  assign hash_cnt      = hash_cnt_q;

endmodule
`default_nettype wire
